// File: rtl/cp0_redirect_ctrl.sv
// Pipeline redirect sequencer for CP0 exception, interrupt and ERET commits:
// freeze, drain data memory, flush every stage, then hand the new PC to fetch.
module cp0_redirect_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hbfc00380,
  parameter int unsigned DRAIN_MAX  = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        excep_cmt,
  input  logic        int_cmt,
  input  logic        eret_cmt,
  input  logic [31:0] epc_value,
  input  logic        mem_busy,
  input  logic        fetch_ready,
  output logic        stall_all,
  output logic [3:0]  flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [1:0]  redirect_cause,
  output logic        drain_timeout,
  output logic        event_lost
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    FLUSH    = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_MAX - 1);

  state_t     state;
  logic [7:0] drain_cnt;
  logic       any_cmt;

  assign any_cmt = excep_cmt | int_cmt | eret_cmt;

  // Outputs are registered alongside the state they belong to, so they only
  // ever reflect registered state and never follow an input combinationally.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      drain_cnt      <= 8'd0;
      stall_all      <= 1'b0;
      flush          <= 4'b0000;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'h0;
      redirect_cause <= 2'b00;
      drain_timeout  <= 1'b0;
      event_lost     <= 1'b0;
    end else begin
      if (state != IDLE && any_cmt) begin
        event_lost <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (any_cmt) begin
            drain_cnt <= 8'd0;
            stall_all <= 1'b1;
            if (excep_cmt) begin
              redirect_cause <= 2'b01;
              redirect_pc    <= EXC_VECTOR;
            end else if (int_cmt) begin
              redirect_cause <= 2'b10;
              redirect_pc    <= EXC_VECTOR;
            end else begin
              redirect_cause <= 2'b11;
              redirect_pc    <= epc_value;
            end
            if (mem_busy) begin
              state <= DRAIN;
            end else begin
              state <= FLUSH;
              flush <= 4'b1111;
            end
          end
        end

        // Counter starts at zero on the first DRAIN cycle, so the timeout
        // fires on the DRAIN_MAX-th cycle spent here.
        DRAIN: begin
          drain_cnt <= drain_cnt + 8'd1;
          if (!mem_busy) begin
            state <= FLUSH;
            flush <= 4'b1111;
          end else if (drain_cnt == DRAIN_LAST) begin
            state         <= FLUSH;
            flush         <= 4'b1111;
            drain_timeout <= 1'b1;
          end
        end

        FLUSH: begin
          state          <= REDIRECT;
          flush          <= 4'b0000;
          redirect_valid <= 1'b1;
        end

        REDIRECT: begin
          if (fetch_ready) begin
            state          <= IDLE;
            stall_all      <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_cause <= 2'b00;
          end
        end

        default: begin
          state          <= IDLE;
          stall_all      <= 1'b0;
          flush          <= 4'b0000;
          redirect_valid <= 1'b0;
          redirect_cause <= 2'b00;
        end
      endcase
    end
  end

endmodule
